// File: rtl/vga_frame_writer_if.sv
// Pixel write bus: one {address, colour} entry per valid/ready handshake.
// Master holds address and data stable while valid is high and ready is low.
interface vga_frame_writer_if #(
    parameter int ADDR_W = 10
) ();
    logic              oWrValid;
    logic              iWrReady;
    logic [ADDR_W-1:0] oWrAddr;
    logic [23:0]       oWrData;

    modport master (output oWrValid, output oWrAddr, output oWrData, input iWrReady);
    modport slave  (input oWrValid, input oWrAddr, input oWrData, output iWrReady);
endinterface

// File: rtl/vga_frame_writer.sv
// Captures one frame of 2-cycle pixels into a small FIFO and streams {addr, rgb} writes.
// Sample to oWrValid is 1 cycle; a full FIFO with no pop drops the pixel and sets oOverflow.
module vga_frame_writer #(
    parameter int H_ACTIVE   = 24,
    parameter int V_ACTIVE   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = $clog2(H_ACTIVE*V_ACTIVE)+1
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iCaptureEn,
    input  logic                      iPixelSync,
    input  logic                      iPixelActive,
    input  logic [7:0]                iDataRed,
    input  logic [7:0]                iDataGreen,
    input  logic [7:0]                iDataBlue,
    vga_frame_writer_if.master        wr,
    output logic                      oBusy,
    output logic                      oFrameDone,
    output logic                      oOverflow,
    output logic                      oFrameError
);
    localparam int                TOTAL   = H_ACTIVE*V_ACTIVE;
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] TOTAL_A = ADDR_W'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(TOTAL-1);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, DRAIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_phase;
    logic [PTR_W:0]      r_wr_ptr;
    logic [PTR_W:0]      r_rd_ptr;
    logic [ADDR_W+23:0]  r_mem [FIFO_DEPTH];
    logic                r_overflow;
    logic                r_frame_error;
    logic                r_last_dropped;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_sample;
    logic                w_frame_end;
    logic                w_early_sync;
    logic                w_cnt_clr;
    logic [ADDR_W+23:0]  w_head;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop        = !w_empty && wr.iWrReady;
    assign w_frame_end  = (r_cnt == TOTAL_A);
    assign w_early_sync = (r_state == CAPTURE) && iPixelSync && !w_frame_end;
    // A sync restarts the frame, so it wins over a coincident sample.
    assign w_sample     = (r_state == CAPTURE) && iPixelActive && r_phase &&
                          !w_frame_end && !iPixelSync;
    assign w_push       = w_sample && (!w_full || w_pop);
    assign w_drop       = w_sample && !w_push;
    assign w_cnt_clr    = ((r_state == WAIT_SYNC) && iCaptureEn && iPixelSync) || w_early_sync;
    assign w_head       = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign wr.oWrValid  = !w_empty;
    assign wr.oWrAddr   = w_empty ? '0 : w_head[ADDR_W+23:24];
    assign wr.oWrData   = w_empty ? '0 : w_head[23:0];

    assign oBusy        = (r_state == WAIT_SYNC) || (r_state == CAPTURE);
    assign oOverflow    = r_overflow;
    assign oFrameError  = r_frame_error;
    // If the final pixel was dropped, completion is signalled when the FIFO runs dry.
    assign oFrameDone   = (w_pop && (w_head[ADDR_W+23:24] == LAST_A)) ||
                          ((r_state == DRAIN) && w_empty && r_last_dropped);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (iCaptureEn) w_next = WAIT_SYNC;
            WAIT_SYNC: begin
                if (!iCaptureEn)     w_next = IDLE;
                else if (iPixelSync) w_next = CAPTURE;
            end
            CAPTURE:   if (w_frame_end) w_next = DRAIN;
            DRAIN:     if (w_empty) w_next = iCaptureEn ? WAIT_SYNC : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_phase        <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_overflow     <= 1'b0;
            r_frame_error  <= 1'b0;
            r_last_dropped <= 1'b0;
        end else begin
            r_state <= w_next;
            r_phase <= iPixelActive ? ~r_phase : 1'b0;
            if (w_cnt_clr) begin
                r_cnt          <= '0;
                r_last_dropped <= 1'b0;
            end else if (w_sample) begin
                r_cnt <= r_cnt + ADDR_W'(1);
                if (w_drop && (r_cnt == LAST_A)) r_last_dropped <= 1'b1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            if (w_drop)       r_overflow    <= 1'b1;
            if (w_early_sync) r_frame_error <= 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_cnt, iDataRed, iDataGreen, iDataBlue};
    end
endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench: stimulus queues expected writes, a negedge monitor checks every accepted write.
module tb_vga_frame_writer;
    localparam int AW    = 10;
    localparam int TOTAL = 384;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iCaptureEn, iPixelSync, iPixelActive;
    logic [7:0] iDataRed, iDataGreen, iDataBlue;
    logic       oBusy, oFrameDone, oOverflow, oFrameError;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [AW+23:0] exp_q[$];

    vga_frame_writer_if #(.ADDR_W(AW)) wr_if ();

    vga_frame_writer #(
        .H_ACTIVE(24), .V_ACTIVE(16), .FIFO_DEPTH(4), .ADDR_W(AW)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iCaptureEn(iCaptureEn), .iPixelSync(iPixelSync),
        .iPixelActive(iPixelActive), .iDataRed(iDataRed), .iDataGreen(iDataGreen),
        .iDataBlue(iDataBlue), .wr(wr_if), .oBusy(oBusy), .oFrameDone(oFrameDone),
        .oOverflow(oOverflow), .oFrameError(oFrameError)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int idx, input logic [7:0] seed);
        logic [8:0] i9;
        i9 = idx[8:0];
        return {i9[7:0], seed, i9[8:1] ^ seed};
    endfunction

    // Monitor: checks hold-while-stalled and pops the scoreboard on each accepted write.
    initial begin
        logic           prev_stall;
        logic [AW-1:0]  prev_addr;
        logic [23:0]    prev_data;
        logic [AW+23:0] e;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge iClk);
            if (prev_stall && !iRst) begin
                check("hold_valid", {31'd0, wr_if.oWrValid}, 32'd1);
                check("hold_addr", {22'd0, wr_if.oWrAddr}, {22'd0, prev_addr});
                check("hold_data", {8'd0, wr_if.oWrData}, {8'd0, prev_data});
            end
            if (wr_if.oWrValid && wr_if.iWrReady) begin
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", {22'd0, wr_if.oWrAddr}, {22'd0, e[AW+23:24]});
                    check("wr_data", {8'd0, wr_if.oWrData}, {8'd0, e[23:0]});
                end
            end
            if (oFrameDone) done_cnt++;
            prev_stall = wr_if.oWrValid && !wr_if.iWrReady;
            prev_addr  = wr_if.oWrAddr;
            prev_data  = wr_if.oWrData;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_pix(input int idx, input logic [7:0] seed, input bit exp_wr,
                            input bit r1, input bit r2);
        logic [23:0] p;
        p = pix(idx, seed);
        if (exp_wr) exp_q.push_back({AW'(idx), p});
        iPixelActive = 1'b1;
        {iDataRed, iDataGreen, iDataBlue} = p;
        wr_if.iWrReady = r1;
        @(posedge iClk); #1;
        wr_if.iWrReady = r2;
        @(posedge iClk); #1;
        wr_if.iWrReady = 1'b1;
    endtask

    task automatic idle(input int n);
        iPixelActive = 1'b0;
        repeat (n) begin @(posedge iClk); #1; end
    endtask

    task automatic sync_pulse();
        iPixelActive = 1'b0;
        iPixelSync   = 1'b1;
        @(posedge iClk); #1;
        iPixelSync   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        iPixelActive = 1'b0;
        while ((exp_q.size() != 0 || wr_if.oWrValid) && n < 300) begin
            @(posedge iClk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        idle(3);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {31'd0, wr_if.oWrValid}, 0);
        check({tag, "_addr"}, {22'd0, wr_if.oWrAddr}, 0);
        check({tag, "_data"}, {8'd0, wr_if.oWrData}, 0);
        check({tag, "_busy"}, {31'd0, oBusy}, 0);
        check({tag, "_done"}, {31'd0, oFrameDone}, 0);
        check({tag, "_ovf"}, {31'd0, oOverflow}, 0);
        check({tag, "_ferr"}, {31'd0, oFrameError}, 0);
    endtask

    initial begin
        iRst = 1'b1; iCaptureEn = 1'b0; iPixelSync = 1'b0; iPixelActive = 1'b0;
        iDataRed = '0; iDataGreen = '0; iDataBlue = '0; wr_if.iWrReady = 1'b1;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check_reset("rst0");
        @(posedge iClk); #1;
        iRst = 1'b0;

        // Full frame with a 4-deep stall released on a sample cycle (full + pop).
        iCaptureEn = 1'b1;
        idle(2);
        check("wait_sync_busy", {31'd0, oBusy}, 1);
        sync_pulse();
        done_cnt = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 100)                 send_pix(i, 8'h11, 1'b1, 1'b1, 1'b0);
            else if (i > 100 && i < 104)  send_pix(i, 8'h11, 1'b1, 1'b0, 1'b0);
            else if (i == 104)            send_pix(i, 8'h11, 1'b1, 1'b0, 1'b1);
            else                          send_pix(i, 8'h11, 1'b1, 1'b1, 1'b1);
            if (i == 0) check("sample_latency", {31'd0, wr_if.oWrValid}, 1);
        end
        drain("full_drain");
        check("full_done_cnt", done_cnt, 1);
        check("full_ovf", {31'd0, oOverflow}, 0);
        check("full_ferr", {31'd0, oFrameError}, 0);
        check("full_rearm_busy", {31'd0, oBusy}, 1);

        // Pixels with no sync are ignored while waiting.
        for (int i = 0; i < 20; i++) send_pix(i, 8'h77, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("nosync_busy", {31'd0, oBusy}, 1);
        check("nosync_valid", {31'd0, wr_if.oWrValid}, 0);

        // Short frame then a full one.
        done_cnt = 0;
        sync_pulse();
        for (int i = 0; i < 100; i++) send_pix(i, 8'h22, 1'b1, 1'b1, 1'b1);
        sync_pulse();
        check("short_ferr", {31'd0, oFrameError}, 1);
        for (int i = 0; i < TOTAL; i++) send_pix(i, 8'h33, 1'b1, 1'b1, 1'b1);
        drain("short_drain");
        check("short_done_cnt", done_cnt, 1);
        check("short_ovf", {31'd0, oOverflow}, 0);

        // 20-cycle stall: pixels 200..203 fit, 204..209 dropped, 210 lands with a pop.
        done_cnt = 0;
        sync_pulse();
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 200)                 send_pix(i, 8'h44, 1'b1, 1'b1, 1'b0);
            else if (i > 200 && i < 210)  send_pix(i, 8'h44, !(i >= 204), 1'b0, 1'b0);
            else if (i == 210)            send_pix(i, 8'h44, 1'b1, 1'b0, 1'b1);
            else                          send_pix(i, 8'h44, 1'b1, 1'b1, 1'b1);
        end
        drain("bp_drain");
        check("bp_ovf", {31'd0, oOverflow}, 1);
        check("bp_done_cnt", done_cnt, 1);

        // Reset right after pixel 49 is sampled; its write must never appear.
        sync_pulse();
        for (int i = 0; i < 50; i++) send_pix(i, 8'h55, i < 49, 1'b1, 1'b1);
        iRst = 1'b1;
        @(negedge iClk);
        check_reset("rst_mid");
        exp_q.delete();
        @(posedge iClk); #1;
        iRst = 1'b0;
        for (int i = 0; i < 10; i++) send_pix(i, 8'h66, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("post_rst_busy", {31'd0, oBusy}, 1);
        check("post_rst_valid", {31'd0, wr_if.oWrValid}, 0);
        sync_pulse();
        for (int i = 0; i < 10; i++) send_pix(i, 8'h66, 1'b1, 1'b1, 1'b1);
        drain("post_rst_drain");
        check("post_rst_ferr", {31'd0, oFrameError}, 0);
        check("post_rst_ovf", {31'd0, oOverflow}, 0);

        iCaptureEn = 1'b0;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
